// File: rtl/axi_lite_pkg.sv
// Shared definitions for the AXI4-Lite slave and its downstream register file.
package axi_lite_pkg;

    localparam int ADDR_WIDTH_SLAVE_DEFAULT = 5;
    localparam int DATA_WIDTH_DEFAULT       = 32;

    // AXI OKAY response code, shared with the slave.
    localparam logic [1:0] RESP_OKAY = 2'b00;

    // Register-file ownership states.
    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_SLAVE   = 2'd1,
        ST_HW      = 2'd2,
        ST_HOLDOFF = 2'd3
    } rf_state_e;

endpackage

// File: rtl/rf_arbiter.sv
// Ownership arbiter between the AXI slave and the hardware-side port.
// A hardware beat keeps the file busy for two cycles. The access itself
// happens on the edge that raises hw_grant. A one-cycle HOLDOFF then
// guarantees the slave a non-busy window before the next hardware beat.
module rf_arbiter
    import axi_lite_pkg::*;
(
    input  logic clk,
    input  logic reset,
    input  logic slave_need_rf,
    input  logic rfrdcmd,
    input  logic hw_req,
    output logic rf_busy,
    output logic hw_grant,
    output logic rd_fire,
    output logic hw_access
);

    rf_state_e state_r;
    rf_state_e state_next_s;
    logic      rf_busy_r;
    logic      hw_grant_r;
    logic      rd_done_r;
    logic      hw_access_s;
    logic      rd_fire_s;

    // State register plus the registered busy, grant and read-session flags.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_r    <= ST_IDLE;
            rf_busy_r  <= 1'b0;
            hw_grant_r <= 1'b0;
            rd_done_r  <= 1'b0;
        end else begin
            state_r    <= state_next_s;
            rf_busy_r  <= (state_next_s == ST_HW);
            hw_grant_r <= hw_access_s;
            if (rd_fire_s) begin
                rd_done_r <= 1'b1;
            end else if (!slave_need_rf) begin
                rd_done_r <= 1'b0;
            end else begin
                rd_done_r <= rd_done_r;
            end
        end
    end

    // Next-state decision. The slave wins a simultaneous request because it
    // cannot back-pressure a write.
    always_comb begin
        state_next_s = state_r;
        case (state_r)
            ST_IDLE: begin
                if (slave_need_rf) begin
                    state_next_s = ST_SLAVE;
                end else if (hw_req) begin
                    state_next_s = ST_HW;
                end else begin
                    state_next_s = ST_IDLE;
                end
            end
            ST_HW: begin
                if (hw_grant_r) begin
                    state_next_s = ST_HOLDOFF;
                end else begin
                    state_next_s = ST_HW;
                end
            end
            ST_HOLDOFF: begin
                if (slave_need_rf) begin
                    state_next_s = ST_SLAVE;
                end else begin
                    state_next_s = ST_IDLE;
                end
            end
            ST_SLAVE: begin
                if (slave_need_rf) begin
                    state_next_s = ST_SLAVE;
                end else begin
                    state_next_s = ST_IDLE;
                end
            end
            default: begin
                state_next_s = ST_IDLE;
            end
        endcase
    end

    // Access strobes: the hardware access fires in the first HW cycle, and
    // the AXI read fires once per ownership session when not busy.
    always_comb begin
        hw_access_s = 1'b0;
        rd_fire_s   = 1'b0;
        if ((state_r == ST_HW) && !hw_grant_r) begin
            hw_access_s = 1'b1;
        end else begin
            hw_access_s = 1'b0;
        end
        if (slave_need_rf && rfrdcmd && !rf_busy_r && !rd_done_r) begin
            rd_fire_s = 1'b1;
        end else begin
            rd_fire_s = 1'b0;
        end
    end

    assign rf_busy   = rf_busy_r;
    assign hw_grant  = hw_grant_r;
    assign rd_fire   = rd_fire_s;
    assign hw_access = hw_access_s;

endmodule

// File: rtl/axi_lite_reg_file.sv
// Register file downstream of the AXI4-Lite slave, shared with a
// single-beat hardware port. All registers are exposed flat on reg_q.
module axi_lite_reg_file
    import axi_lite_pkg::*;
#(
    parameter int ADDR_WIDTH_SLAVE = ADDR_WIDTH_SLAVE_DEFAULT,
    parameter int DATA_WIDTH       = DATA_WIDTH_DEFAULT,
    parameter logic [(2**ADDR_WIDTH_SLAVE)-1:0] RO_MASK = 32'h0000_0001,
    parameter logic [DATA_WIDTH-1:0] RESET_VAL = {DATA_WIDTH{1'b0}}
) (
    input  logic                        clk,
    input  logic                        reset,
    input  logic                        rfwrcmd,
    input  logic [ADDR_WIDTH_SLAVE-1:0] rfwraddr,
    input  logic [DATA_WIDTH-1:0]       rfwrdata,
    input  logic                        rfrdcmd,
    input  logic [ADDR_WIDTH_SLAVE-1:0] rfrdaddr,
    input  logic                        slave_need_rf,
    output logic [DATA_WIDTH-1:0]       rfrddata,
    output logic                        rf_data_valid,
    output logic                        rf_busy,
    input  logic                        hw_req,
    input  logic                        hw_we,
    input  logic [ADDR_WIDTH_SLAVE-1:0] hw_addr,
    input  logic [DATA_WIDTH-1:0]       hw_wrdata,
    output logic                        hw_grant,
    output logic [DATA_WIDTH-1:0]       hw_rddata,
    output logic                        hw_rdvalid,
    output logic [(2**ADDR_WIDTH_SLAVE)*DATA_WIDTH-1:0] reg_q
);

    localparam int NUM_REGS = 2**ADDR_WIDTH_SLAVE;

    logic [DATA_WIDTH-1:0] regs_r [NUM_REGS];
    logic [DATA_WIDTH-1:0] rfrddata_r;
    logic                  rf_data_valid_r;
    logic [DATA_WIDTH-1:0] hw_rddata_r;
    logic                  hw_rd_pend_r;
    logic                  hw_rdvalid_r;
    logic                  rf_busy_s;
    logic                  rd_fire_s;
    logic                  hw_access_s;
    logic                  axi_wr_s;

    rf_arbiter u_arbiter (
        .clk           (clk),
        .reset         (reset),
        .slave_need_rf (slave_need_rf),
        .rfrdcmd       (rfrdcmd),
        .hw_req        (hw_req),
        .rf_busy       (rf_busy_s),
        .hw_grant      (hw_grant),
        .rd_fire       (rd_fire_s),
        .hw_access     (hw_access_s)
    );

    // AXI writes land whenever the file is not busy, even before ownership
    // is formally taken; read-only registers silently drop them.
    assign axi_wr_s = rfwrcmd && !rf_busy_s && !RO_MASK[rfwraddr];

    // Register storage; the two writers never coincide because AXI writes
    // are blocked while a hardware beat is in progress.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int i = 0; i < NUM_REGS; i++) begin
                regs_r[i] <= RESET_VAL;
            end
        end else begin
            for (int i = 0; i < NUM_REGS; i++) begin
                if (hw_access_s && hw_we && (hw_addr == ADDR_WIDTH_SLAVE'(i))) begin
                    regs_r[i] <= hw_wrdata;
                end else if (axi_wr_s && (rfwraddr == ADDR_WIDTH_SLAVE'(i))) begin
                    regs_r[i] <= rfwrdata;
                end else begin
                    regs_r[i] <= regs_r[i];
                end
            end
        end
    end

    // AXI read data: captured once per session and held until ownership drops.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            rfrddata_r      <= {DATA_WIDTH{1'b0}};
            rf_data_valid_r <= 1'b0;
        end else if (rd_fire_s) begin
            rfrddata_r      <= regs_r[rfrdaddr];
            rf_data_valid_r <= 1'b1;
        end else if (!slave_need_rf) begin
            rfrddata_r      <= {DATA_WIDTH{1'b0}};
            rf_data_valid_r <= 1'b0;
        end else begin
            rfrddata_r      <= rfrddata_r;
            rf_data_valid_r <= rf_data_valid_r;
        end
    end

    // Hardware read data: captured at grant, flagged valid one cycle later.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            hw_rddata_r  <= {DATA_WIDTH{1'b0}};
            hw_rd_pend_r <= 1'b0;
            hw_rdvalid_r <= 1'b0;
        end else begin
            if (hw_access_s && !hw_we) begin
                hw_rddata_r <= regs_r[hw_addr];
            end else begin
                hw_rddata_r <= hw_rddata_r;
            end
            hw_rd_pend_r <= hw_access_s && !hw_we;
            hw_rdvalid_r <= hw_rd_pend_r;
        end
    end

    for (genvar g = 0; g < NUM_REGS; g++) begin : g_flat
        assign reg_q[g*DATA_WIDTH +: DATA_WIDTH] = regs_r[g];
    end

    assign rfrddata      = rfrddata_r;
    assign rf_data_valid = rf_data_valid_r;
    assign rf_busy       = rf_busy_s;
    assign hw_rddata     = hw_rddata_r;
    assign hw_rdvalid    = hw_rdvalid_r;

endmodule

// File: tb/tb_axi_lite_reg_file.sv
// Self-checking bench for axi_lite_reg_file against an array-based model.
module tb_axi_lite_reg_file;

    localparam int AW = 5;
    localparam int DW = 32;
    localparam int NR = 32;

    logic          clk = 1'b0;
    logic          reset;
    logic          rfwrcmd;
    logic [AW-1:0] rfwraddr;
    logic [DW-1:0] rfwrdata;
    logic          rfrdcmd;
    logic [AW-1:0] rfrdaddr;
    logic          slave_need_rf;
    logic [DW-1:0] rfrddata;
    logic          rf_data_valid;
    logic          rf_busy;
    logic          hw_req;
    logic          hw_we;
    logic [AW-1:0] hw_addr;
    logic [DW-1:0] hw_wrdata;
    logic          hw_grant;
    logic [DW-1:0] hw_rddata;
    logic          hw_rdvalid;
    logic [NR*DW-1:0] reg_q;

    logic [NR-1:0] ro_mask_v = 32'h0000_0001;
    logic [DW-1:0] model [NR];
    int checks   = 0;
    int failures = 0;
    int busy_run = 0;
    int busy_max = 0;
    int n;
    int op;
    logic [AW-1:0] a;
    logic [DW-1:0] d;

    axi_lite_reg_file dut (
        .clk           (clk),
        .reset         (reset),
        .rfwrcmd       (rfwrcmd),
        .rfwraddr      (rfwraddr),
        .rfwrdata      (rfwrdata),
        .rfrdcmd       (rfrdcmd),
        .rfrdaddr      (rfrdaddr),
        .slave_need_rf (slave_need_rf),
        .rfrddata      (rfrddata),
        .rf_data_valid (rf_data_valid),
        .rf_busy       (rf_busy),
        .hw_req        (hw_req),
        .hw_we         (hw_we),
        .hw_addr       (hw_addr),
        .hw_wrdata     (hw_wrdata),
        .hw_grant      (hw_grant),
        .hw_rddata     (hw_rddata),
        .hw_rdvalid    (hw_rdvalid),
        .reg_q         (reg_q)
    );

    always #5 clk = ~clk;

    // Longest run of consecutive busy cycles.
    always @(negedge clk) begin
        if (rf_busy) begin
            busy_run <= busy_run + 1;
            if (busy_run + 1 > busy_max) busy_max <= busy_run + 1;
        end else begin
            busy_run <= 0;
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic chk_regq(input string tag);
        int bad;
        bad = -1;
        for (int i = 0; i < NR; i++) begin
            if ((reg_q[i*DW +: DW] !== model[i]) && (bad < 0)) bad = i;
        end
        checks++;
        assert (bad < 0) else begin
            failures++;
            $error("FAIL %s reg=%0d observed=%0h expected=%0h", tag, bad,
                   reg_q[bad*DW +: DW], model[bad]);
        end
    endtask

    task automatic axi_write(input logic [AW-1:0] wa, input logic [DW-1:0] wd);
        slave_need_rf = 1'b1;
        rfwrcmd  = 1'b1;
        rfwraddr = wa;
        rfwrdata = wd;
        step();
        rfwrcmd = 1'b0;
        slave_need_rf = 1'b0;
        if (!ro_mask_v[wa]) model[wa] = wd;
        step();
    endtask

    task automatic axi_read(input logic [AW-1:0] ra);
        slave_need_rf = 1'b1;
        rfrdcmd  = 1'b1;
        rfrdaddr = ra;
        chk("rd_valid_before", rf_data_valid, 1'b0);
        step();
        chk("rd_valid", rf_data_valid, 1'b1);
        chk("rd_data", rfrddata, model[ra]);
        rfrdaddr = ra ^ 5'd1;
        step();
        chk("rd_no_retrigger", rfrddata, model[ra]);
        rfrdcmd = 1'b0;
        step();
        chk("rd_valid_hold", rf_data_valid, 1'b1);
        slave_need_rf = 1'b0;
        step();
        chk("rd_valid_clear", rf_data_valid, 1'b0);
        chk("rd_data_clear", rfrddata, 32'h0);
    endtask

    task automatic hw_op(input logic we, input logic [AW-1:0] ha, input logic [DW-1:0] hd);
        int cnt;
        cnt = 0;
        hw_req = 1'b1;
        hw_we = we;
        hw_addr = ha;
        hw_wrdata = hd;
        while (!hw_grant && cnt < 20) begin
            step();
            cnt++;
        end
        chk("hw_grant_seen", hw_grant, 1'b1);
        chk("hw_grant_lat", cnt, 2);
        chk("hw_busy_at_grant", rf_busy, 1'b1);
        if (we) model[ha] = hd;
        hw_req = 1'b0;
        step();
        chk("hw_grant_pulse", hw_grant, 1'b0);
        chk("hw_busy_holdoff", rf_busy, 1'b0);
        chk("hw_rdvalid", hw_rdvalid, !we);
        if (!we) chk("hw_rddata", hw_rddata, model[ha]);
        step();
        chk("hw_rdvalid_pulse", hw_rdvalid, 1'b0);
    endtask

    initial begin
        reset = 1'b1;
        rfwrcmd = 1'b0; rfwraddr = '0; rfwrdata = '0;
        rfrdcmd = 1'b0; rfrdaddr = '0; slave_need_rf = 1'b0;
        hw_req = 1'b0; hw_we = 1'b0; hw_addr = '0; hw_wrdata = '0;
        for (int i = 0; i < NR; i++) model[i] = 32'h0;
        repeat (2) @(posedge clk);
        #1;
        chk("rst_busy", rf_busy, 1'b0);
        chk("rst_grant", hw_grant, 1'b0);
        chk("rst_rdvalid", rf_data_valid, 1'b0);
        chk("rst_rddata", rfrddata, 32'h0);
        chk("rst_hwrdvalid", hw_rdvalid, 1'b0);
        chk("rst_hwrddata", hw_rddata, 32'h0);
        chk_regq("rst_regq");
        reset = 1'b0;
        step();

        // AXI write then read.
        axi_write(5'd5, 32'hDEAD_BEEF);
        chk("wr5_slice", reg_q[5*DW +: DW], 32'hDEAD_BEEF);
        axi_read(5'd5);

        // Read-only protection, hardware side may still write.
        axi_write(5'd0, 32'h0000_1234);
        chk("ro_blocked", reg_q[DW-1:0], 32'h0);
        hw_op(1'b1, 5'd0, 32'h0000_0055);
        chk("ro_hw_write", reg_q[DW-1:0], 32'h0000_0055);
        axi_read(5'd0);

        // Simultaneous request: slave wins.
        slave_need_rf = 1'b1;
        hw_req = 1'b1; hw_we = 1'b1; hw_addr = 5'd7; hw_wrdata = 32'hA5A5_0007;
        for (int i = 0; i < 4; i++) begin
            step();
            chk("sim_busy", rf_busy, 1'b0);
            chk("sim_grant", hw_grant, 1'b0);
        end
        slave_need_rf = 1'b0;
        n = 0;
        while (!hw_grant && n < 20) begin step(); n++; end
        chk("sim_grant_after", n, 3);
        model[7] = 32'hA5A5_0007;
        hw_req = 1'b0;
        step();
        step();
        chk_regq("sim_regq");

        // Contention: slave arrives during a hardware beat.
        axi_write(5'd10, 32'h0BAD_F00D);
        hw_req = 1'b1; hw_we = 1'b1; hw_addr = 5'd9; hw_wrdata = 32'hC0FF_EE09;
        step();
        chk("cont_busy0", rf_busy, 1'b1);
        slave_need_rf = 1'b1; rfrdcmd = 1'b1; rfrdaddr = 5'd9;
        step();
        chk("cont_grant", hw_grant, 1'b1);
        chk("cont_busy1", rf_busy, 1'b1);
        chk("cont_novalid1", rf_data_valid, 1'b0);
        hw_req = 1'b0;
        model[9] = 32'hC0FF_EE09;
        step();
        chk("cont_busy2", rf_busy, 1'b0);
        chk("cont_novalid2", rf_data_valid, 1'b0);
        step();
        chk("cont_valid", rf_data_valid, 1'b1);
        chk("cont_data", rfrddata, 32'hC0FF_EE09);
        rfrdaddr = 5'd10;
        step();
        chk("cont_one_read", rfrddata, 32'hC0FF_EE09);
        rfrdcmd = 1'b0;
        step();
        chk("cont_hold", rf_data_valid, 1'b1);
        slave_need_rf = 1'b0;
        step();
        chk("cont_clear", rf_data_valid, 1'b0);

        // Hardware back-to-back reads of regs 1..4.
        for (int k = 1; k <= 4; k++) axi_write(AW'(k), $urandom);
        hw_req = 1'b1; hw_we = 1'b0;
        for (int k = 1; k <= 4; k++) begin
            hw_addr = AW'(k);
            n = 0;
            while (!hw_grant && n < 20) begin step(); n++; end
            chk("b2b_grant", hw_grant, 1'b1);
            chk("b2b_gap", n, (k == 1) ? 2 : 3);
            if (k == 4) hw_req = 1'b0;
            step();
            chk("b2b_rdvalid", hw_rdvalid, 1'b1);
            chk("b2b_rddata", hw_rddata, model[k]);
            chk("b2b_grant_pulse", hw_grant, 1'b0);
        end
        step();

        // Randomised mix against the model.
        for (int it = 0; it < 30; it++) begin
            op = $urandom_range(0, 3);
            a = AW'($urandom_range(0, NR - 1));
            d = $urandom;
            case (op)
                0: axi_write(a, d);
                1: axi_read(a);
                2: hw_op(1'b1, a, d);
                default: hw_op(1'b0, a, d);
            endcase
            chk_regq("rand_regq");
        end

        // Asynchronous reset in the middle of a slave read session.
        slave_need_rf = 1'b1; rfrdcmd = 1'b1; rfrdaddr = 5'd5;
        step();
        chk("arst_pre_valid", rf_data_valid, 1'b1);
        #2;
        reset = 1'b1;
        #1;
        for (int i = 0; i < NR; i++) model[i] = 32'h0;
        chk("arst_valid", rf_data_valid, 1'b0);
        chk("arst_rddata", rfrddata, 32'h0);
        chk("arst_busy", rf_busy, 1'b0);
        chk_regq("arst_regq");
        slave_need_rf = 1'b0; rfrdcmd = 1'b0;
        @(negedge clk);
        reset = 1'b0;
        step();
        hw_op(1'b0, 5'd5, 32'h0);

        chk("busy_max", busy_max, 2);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/axi_lite_reg_file.md
Name: axi_lite_reg_file

Overview:
- Register file that sits directly downstream of the AXI4-Lite slave.
- Serves that slave's rf* command interface: address, write pulse, read command, busy, data-valid and the slave_need_rf ownership flag.
- Arbitrates against a single-beat hardware-side port used by the control logic.
- Exposes every register as a flat bus for the control datapath.

Parameters:
- ADDR_WIDTH_SLAVE, 5: register address width; NUM_REGS = 2**ADDR_WIDTH_SLAVE.
- DATA_WIDTH, 32: register width.
- RO_MASK, 32'h0000_0001: bit i set means register i is read-only from the AXI side. Hardware-side writes are still allowed.
- RESET_VAL, 0: reset value of every register.

Ports:
- clk  in  1  system clock; all logic on rising edge.
- reset  in  1  asynchronous, active-high reset.
- rfwrcmd  in  1  AXI-side write strobe, one-cycle pulse.
- rfwraddr  in  ADDR_WIDTH_SLAVE  AXI-side write address.
- rfwrdata  in  DATA_WIDTH  AXI-side write data.
- rfrdcmd  in  1  AXI-side read command; may be held several cycles.
- rfrdaddr  in  ADDR_WIDTH_SLAVE  AXI-side read address.
- slave_need_rf  in  1  AXI slave requests ownership; high for the whole transaction.
- rfrddata  out  DATA_WIDTH  AXI-side read data.
- rf_data_valid  out  1  rfrddata valid.
- rf_busy  out  1  file owned by hardware side.
- hw_req  in  1  hardware-side access request; held until hw_grant.
- hw_we  in  1  1 = write, 0 = read; stable while hw_req is high.
- hw_addr  in  ADDR_WIDTH_SLAVE  hardware-side address.
- hw_wrdata  in  DATA_WIDTH  hardware-side write data.
- hw_grant  out  1  one-cycle pulse: access performed.
- hw_rddata  out  DATA_WIDTH  hardware read data, valid with hw_rdvalid.
- hw_rdvalid  out  1  one-cycle pulse, the cycle after a read hw_grant.
- reg_q  out  NUM_REGS*DATA_WIDTH  flat image of all registers; register i occupies bits [i*DATA_WIDTH +: DATA_WIDTH].

Behaviour:
- Reset (asynchronous, takes effect immediately): all registers = RESET_VAL, FSM = IDLE, all outputs 0.
  - Reset mid-operation abandons any ownership or pending read.
- FSM states:
  - IDLE: slave_need_rf=1 -> SLAVE. Else hw_req=1 -> HW.
    - If both request in the same cycle, the slave wins: the slave cannot back-pressure a write.
  - HW: rf_busy=1. Next cycle perform the access and pulse hw_grant -> HOLDOFF.
  - HOLDOFF: one cycle, rf_busy=0.
    - slave_need_rf=1 -> SLAVE, else IDLE.
    - Guarantees the slave at least one non-busy window between hardware beats.
  - SLAVE: rf_busy=0. Stay until slave_need_rf=0, then -> IDLE.
    - hw_req is ignored while in SLAVE.
- If slave_need_rf rises during HW, rf_busy stays high only for the remaining cycle of that beat; the next state is HOLDOFF, then SLAVE.
  - rf_busy is therefore never high for more than 2 consecutive cycles.
- AXI read:
  - Performed once per ownership session, on the first cycle where rfrdcmd=1 and rf_busy=0.
  - rfrddata <= reg[rfrdaddr] and rf_data_valid <= 1 on the following edge (1-cycle latency).
  - rf_data_valid and rfrddata are held until slave_need_rf=0, then cleared to 0 in the next cycle.
  - A still-high rfrdcmd does not re-trigger the read; a session done-flag prevents it and clears with slave_need_rf.
- AXI write:
  - rfwrcmd=1 while rf_busy=0 -> reg[rfwraddr] <= rfwrdata on that edge, unless RO_MASK[rfwraddr]=1, in which case the write is silently dropped.
  - rfwrcmd while rf_busy=1 is ignored; the slave never issues it then.
  - An AXI write is honoured even in IDLE in the same cycle slave_need_rf rises; no ownership lag.
- Hardware read: hw_rddata <= reg[hw_addr] at grant; hw_rdvalid pulses the next cycle.
- Hardware write: reg[hw_addr] <= hw_wrdata at grant, RO_MASK ignored.
- reg_q reflects register contents one cycle after the write edge (registered storage, no bypass).
- Address width exactly covers NUM_REGS, so there are no out-of-range addresses.

Decomposition:
- Shared package axi_lite_pkg holds:
  - the FSM state encodings (IDLE, SLAVE, HW, HOLDOFF);
  - the default ADDR_WIDTH_SLAVE and DATA_WIDTH values;
  - the RESP_OKAY constant 2'b00, shared with the slave.
- One natural sub-module, rf_arbiter: FSM plus rf_busy, hw_grant and the session done-flag.
- Storage and read muxes stay in the top module.

Test Plan:
- AXI write then read: write 0xDEADBEEF to reg 5, then read reg 5 -> rf_data_valid 1 cycle after rfrdcmd; rfrddata=0xDEADBEEF; reg_q slice 5 matches.
- Read-only protect: AXI write 0x1234 to reg 0 (RO_MASK bit0) -> reg 0 stays 0. Hardware write 0x55 to reg 0 -> AXI read returns 0x55.
- Simultaneous request: slave_need_rf and hw_req rise on the same cycle -> SLAVE granted, rf_busy stays 0, hw_grant only after slave_need_rf falls.
- Contention: slave_need_rf rises while in HW -> rf_busy high at most 2 cycles; the read is issued after busy falls and returns the correct data; rfrdcmd held 3 cycles yields exactly one read.
- Hardware back-to-back: hw_req held for 4 reads of regs 1..4 -> hw_grant pulses spaced by HOLDOFF; hw_rdvalid data correct.
- Async reset mid-SLAVE read: reset asserted between clock edges -> outputs 0 immediately, registers = RESET_VAL, FSM = IDLE after release.
